// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants, DMA state encodings and read-tag codes for the memory
// bus controller and its OAM DMA sequencer.
package mem_bus_ctrl_pkg;

  localparam int REG_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 16;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
  localparam logic [7:0]  DMA_LAST_IDX      = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DMA_HALT  = 3'd1,
    ST_DMA_ALIGN = 3'd2,
    ST_DMA_READ  = 3'd3,
    ST_DMA_WRITE = 3'd4
  } dma_state_t;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_FETCH = 2'b01,
    TAG_EXEC  = 2'b10
  } rd_tag_t;

  // The DMA owns the bus registers only while it is moving a byte.
  function automatic logic dma_drives_bus(input dma_state_t s);
    return (s == ST_DMA_READ) || (s == ST_DMA_WRITE);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_oam_dma_seq.sv
// OAM DMA sequencer: halt, optional align, then 256 read/write pairs copying
// one source page to the OAM data port. Bus values are for the next cycle.
module oam_dma_seq
  import mem_bus_ctrl_pkg::*;
#(
  parameter int                    REG_WIDTH     = REG_WIDTH_DEF,
  parameter int                    ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [REG_WIDTH-1:0]  start_page,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  dma_active,
  output logic                  last_write,
  output logic                  bus_load,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_wdata,
  output logic                  bus_we
);

  dma_state_t           state_reg, state_next;
  logic [REG_WIDTH-1:0] page_reg, page_next;
  logic [7:0]           idx_reg, idx_next;
  logic [REG_WIDTH-1:0] buffer_reg, buffer_next;
  logic                 cycle_odd_reg;

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      page_reg      <= '0;
      idx_reg       <= '0;
      buffer_reg    <= '0;
      cycle_odd_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      page_reg      <= page_next;
      idx_reg       <= idx_next;
      buffer_reg    <= buffer_next;
      cycle_odd_reg <= ~cycle_odd_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    page_next   = page_reg;
    idx_next    = idx_reg;
    buffer_next = buffer_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_DMA_HALT;
          page_next  = start_page;
          idx_next   = 8'h00;
        end
      end
      // An odd halt cycle already puts the first read on an even cycle.
      ST_DMA_HALT:  state_next = cycle_odd_reg ? ST_DMA_READ : ST_DMA_ALIGN;
      ST_DMA_ALIGN: state_next = ST_DMA_READ;
      ST_DMA_READ: begin
        buffer_next = mem_rdata;
        state_next  = ST_DMA_WRITE;
      end
      ST_DMA_WRITE: begin
        if (idx_reg == DMA_LAST_IDX) begin
          state_next = ST_IDLE;
          idx_next   = 8'h00;
        end else begin
          state_next = ST_DMA_READ;
          idx_next   = idx_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dma_active = (state_reg != ST_IDLE);
    last_write = (state_reg == ST_DMA_WRITE) && (idx_reg == DMA_LAST_IDX);
    bus_load   = dma_drives_bus(state_next);
    bus_we     = (state_next == ST_DMA_WRITE);
    bus_wdata  = buffer_next;
    // idx wraps inside the page; the page byte never takes a carry.
    bus_addr   = bus_we ? OAM_DATA_ADDR : {page_next, idx_next};
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus arbiter: exec beats fetch, registered bus outputs, one-cycle
// read capture with owner tag, and the OAM DMA sequencer stalling both.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int                    REG_WIDTH     = REG_WIDTH_DEF,
  parameter int                    ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [REG_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [1:0]            rd_tag,
  output logic                  dma_active,
  output logic                  cpu_stall
);

  logic                  fetch_gnt_reg, fetch_gnt_next;
  logic                  exec_gnt_reg, exec_gnt_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [REG_WIDTH-1:0]  mem_wdata_reg, mem_wdata_next;
  logic                  mem_we_reg, mem_we_next;
  logic [REG_WIDTH-1:0]  rd_data_reg, rd_data_next;
  logic                  rd_valid_reg, rd_valid_next;
  rd_tag_t               rd_tag_reg, rd_tag_next;

  logic                  dma_start;
  logic                  dma_busy;
  logic                  dma_last_write;
  logic                  dma_bus_load;
  logic [ADDR_WIDTH-1:0] dma_bus_addr;
  logic [REG_WIDTH-1:0]  dma_bus_wdata;
  logic                  dma_bus_we;
  logic                  bus_free;
  logic                  grant_exec;
  logic                  grant_fetch;
  logic                  exec_read_done;

  // The $4014 write is on the bus this cycle; the sequencer takes over next.
  assign dma_start = exec_gnt_reg & mem_we_reg & (mem_addr_reg == DMA_REG_ADDR);

  // The edge closing the last DMA write already hands the bus back.
  assign bus_free    = (~dma_busy & ~dma_start) | dma_last_write;
  assign grant_exec  = bus_free & exec_req;
  assign grant_fetch = bus_free & fetch_req & ~exec_req;

  oam_dma_seq #(
    .REG_WIDTH    (REG_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_dma_seq (
    .phi1      (phi1),
    .reset_n   (reset_n),
    .start     (dma_start),
    .start_page(mem_wdata_reg),
    .mem_rdata (mem_rdata),
    .dma_active(dma_busy),
    .last_write(dma_last_write),
    .bus_load  (dma_bus_load),
    .bus_addr  (dma_bus_addr),
    .bus_wdata (dma_bus_wdata),
    .bus_we    (dma_bus_we)
  );

  always_comb begin
    fetch_gnt_next = grant_fetch;
    exec_gnt_next  = grant_exec;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    if (dma_bus_load) begin
      mem_addr_next  = dma_bus_addr;
      mem_wdata_next = dma_bus_wdata;
      mem_we_next    = dma_bus_we;
    end else if (grant_exec) begin
      mem_addr_next  = exec_addr;
      mem_wdata_next = exec_wdata;
      mem_we_next    = exec_we;
    end else if (grant_fetch) begin
      mem_addr_next  = fetch_addr;
    end
  end

  assign exec_read_done = exec_gnt_reg & ~mem_we_reg;

  always_comb begin
    rd_valid_next = fetch_gnt_reg | exec_read_done;
    rd_data_next  = rd_valid_next ? mem_rdata : rd_data_reg;
    rd_tag_next   = TAG_NONE;
    if (fetch_gnt_reg) begin
      rd_tag_next = TAG_FETCH;
    end else if (exec_read_done) begin
      rd_tag_next = TAG_EXEC;
    end
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      fetch_gnt_reg <= 1'b0;
      exec_gnt_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      rd_tag_reg    <= TAG_NONE;
    end else begin
      fetch_gnt_reg <= fetch_gnt_next;
      exec_gnt_reg  <= exec_gnt_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      rd_data_reg   <= rd_data_next;
      rd_valid_reg  <= rd_valid_next;
      rd_tag_reg    <= rd_tag_next;
    end
  end

  assign fetch_gnt  = fetch_gnt_reg;
  assign exec_gnt   = exec_gnt_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_we     = mem_we_reg;
  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_tag     = rd_tag_reg;
  assign dma_active = dma_busy;
  assign cpu_stall  = dma_busy;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: scoreboarded reads, arbitration
// order, OAM DMA with and without align, fetch held over DMA, mid-DMA reset.
module tb_mem_bus_ctrl;

  logic        phi1 = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_gnt;
  logic        exec_req = 1'b0;
  logic        exec_we = 1'b0;
  logic [15:0] exec_addr = '0;
  logic [7:0]  exec_wdata = '0;
  logic        exec_gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [1:0]  rd_tag;
  logic        dma_active;
  logic        cpu_stall;

  logic [7:0]  mem [0:65535];
  logic [9:0]  exp_q [$];
  logic [7:0]  oam_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc;

  always #5 phi1 = ~phi1;

  assign mem_rdata = mem[mem_addr];

  mem_bus_ctrl dut (
    .phi1(phi1), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
    .exec_wdata(exec_wdata), .exec_gnt(exec_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_tag(rd_tag), .dma_active(dma_active), .cpu_stall(cpu_stall)
  );

  // Number of rising edges since reset release; cycle n follows edge n.
  always @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read results: popped whenever the DUT presents rd_valid.
  always @(negedge phi1) begin
    if (reset_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rd_tag", {30'd0, rd_tag}, {30'd0, e[9:8]});
        check("rd_data", {24'd0, rd_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic fetch_once(input logic [15:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    exp_q.push_back({2'b01, mem[addr]});
    @(negedge phi1);
    check("fetch_gnt", {31'd0, fetch_gnt}, 1);
    check("fetch_addr", {16'd0, mem_addr}, {16'd0, addr});
    check("fetch_we", {31'd0, mem_we}, 0);
    fetch_req = 1'b0;
    @(negedge phi1);
    check("fetch_gnt_pulse", {31'd0, fetch_gnt}, 0);
    check("fetch_rd_valid", {31'd0, rd_valid}, 1);
    @(negedge phi1);
    check("rd_valid_one", {31'd0, rd_valid}, 0);
  endtask

  task automatic dma_run(input logic [7:0] page, input bit halt_even,
                         input bit hold_fetch, input bit abort_mid);
    int stall, bad_gnt, pos, n_pre, k, i;
    bit done, aborted;
    logic [15:0] exp_addr;
    logic exp_we;
    stall = 0; bad_gnt = 0; pos = 0; done = 0; aborted = 0;
    n_pre = halt_even ? 2 : 1;
    // HALT is two edges after the drive point, so match parity now.
    while (cyc[0] != !halt_even) @(negedge phi1);
    exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h4014; exec_wdata = page;
    for (int j = 0; j < 256; j++) oam_q.push_back(mem[{page, j[7:0]}]);
    @(negedge phi1);
    check("trig_gnt", {31'd0, exec_gnt}, 1);
    check("trig_bus", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h4014, page});
    check("trig_active", {31'd0, dma_active}, 0);
    exec_req = 1'b0; exec_we = 1'b0;
    if (hold_fetch) begin
      fetch_req = 1'b1; fetch_addr = 16'h8000;
      exp_q.push_back({2'b01, mem[16'h8000]});
    end
    for (int n = 0; n < 600; n++) begin
      @(negedge phi1);
      if (!dma_active) begin done = 1; break; end
      if (cpu_stall) stall++;
      if (fetch_gnt || exec_gnt) bad_gnt++;
      if (pos < n_pre) begin
        exp_addr = 16'h4014; exp_we = 1'b0;
      end else begin
        k = pos - n_pre; i = k / 2;
        exp_we = k[0];
        exp_addr = exp_we ? 16'h2004 : {page, i[7:0]};
        if (!exp_we && i == 0) check("dma_read_even", {31'd0, cyc[0]}, 0);
      end
      check("dma_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
      check("dma_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_we && mem_we) begin
        if (oam_q.size() == 0) check("oam_extra", 1, 0);
        else check("oam_data", {24'd0, mem_wdata}, {24'd0, oam_q.pop_front()});
      end
      if (abort_mid && pos >= n_pre && !exp_we && i == 8'h40) begin
        reset_n = 1'b0;
        #1;
        check("rst_mid_active", {30'd0, dma_active, cpu_stall}, 0);
        check("rst_mid_bus", {15'd0, mem_we, mem_addr}, 0);
        check("rst_mid_tag", {30'd0, rd_tag}, 0);
        oam_q.delete();
        aborted = 1; done = 1;
        break;
      end
      pos++;
    end
    if (!done) check("dma_timeout", 0, 1);
    if (aborted) begin
      repeat (2) @(negedge phi1);
      reset_n = 1'b1;
      @(negedge phi1);
      check("post_rst_idle", {15'd0, dma_active, mem_addr}, 0);
    end else if (done) begin
      check("stall_cycles", stall, halt_even ? 514 : 513);
      check("gnt_in_dma", bad_gnt, 0);
      check("oam_left", oam_q.size(), 0);
      if (hold_fetch) begin
        check("fetch_after_dma", {15'd0, fetch_gnt, mem_addr}, {15'd0, 1'b1, 16'h8000});
        fetch_req = 1'b0;
        @(negedge phi1);
        check("fetch_after_rd", {31'd0, rd_valid}, 1);
      end else begin
        check("no_gnt_after", {31'd0, fetch_gnt | exec_gnt}, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 13 + (a >> 8) * 7 + 1);
    mem[16'h8000] = 8'hA9;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge phi1);
    check("rst_bus", {7'd0, mem_addr, mem_wdata, mem_we}, 0);
    check("rst_ctl", {24'd0, fetch_gnt, exec_gnt, rd_valid, rd_tag, dma_active, cpu_stall}, 0);
    check("rst_rdata", {24'd0, rd_data}, 0);
    reset_n = 1'b1;
    @(negedge phi1);

    fetch_once(16'h8000);

    // Simultaneous requests: exec first, fetch next cycle.
    exec_req = 1'b1; exec_we = 1'b0; exec_addr = 16'h0010;
    fetch_req = 1'b1; fetch_addr = 16'h8001;
    exp_q.push_back({2'b10, mem[16'h0010]});
    exp_q.push_back({2'b01, mem[16'h8001]});
    @(negedge phi1);
    check("both_exec_first", {30'd0, exec_gnt, fetch_gnt}, 2'b10);
    check("both_exec_addr", {16'd0, mem_addr}, 16'h0010);
    exec_req = 1'b0;
    @(negedge phi1);
    check("both_fetch_next", {30'd0, exec_gnt, fetch_gnt}, 2'b01);
    check("both_fetch_addr", {16'd0, mem_addr}, 16'h8001);
    fetch_req = 1'b0;
    @(negedge phi1);
    check("both_b2b_valid", {31'd0, rd_valid}, 1);
    @(negedge phi1);

    // Plain exec write produces no read result and releases mem_we.
    exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h0300; exec_wdata = 8'h5A;
    @(negedge phi1);
    check("wr_bus", {7'd0, exec_gnt, mem_we, mem_addr, mem_wdata}, {7'd0, 2'b11, 16'h0300, 8'h5A});
    exec_req = 1'b0; exec_we = 1'b0;
    @(negedge phi1);
    check("wr_after", {14'd0, rd_valid, mem_we, mem_addr}, {16'd0, 16'h0300});

    dma_run(8'h02, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge phi1);
    dma_run(8'h02, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge phi1);
    dma_run(8'hFF, 1'b0, 1'b0, 1'b1);
    fetch_once(16'h8000);

    repeat (3) @(negedge phi1);
    check("rd_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
